adcmem_writer: RTL and testbench
================================

ADCMEM_WRITER -- requirements
Module: adcmem_writer

Interface
REQ-001 Parameter NUM_CH, default 64, meaning channels per ADC frame; power of two; NUM_CH*FRAMES_PER_BANK SHALL equal 256.
REQ-002 Parameter FRAMES_PER_BANK, default 4, meaning frames per 256-word memory bank.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port enable  input  1  capture enable, level.
REQ-006 Port s_valid  input  1  ADC sample valid.
REQ-007 Port s_data  input  16  ADC sample value.
REQ-008 Port s_chan  input  log2(NUM_CH)  channel index of s_data.
REQ-009 Port s_ready  output  1  writer accepts sample this cycle.
REQ-010 Port bank_release  input  2  one-cycle pulse per bank; consumer finished reading that bank.
REQ-011 Port mem_addr  output  9  sample memory write address.
REQ-012 Port mem_din  output  16  sample memory write data.
REQ-013 Port mem_we  output  1  sample memory write enable.
REQ-014 Port bank_full  output  2  level flag per bank; bank holds a complete, unreleased block.
REQ-015 Port bank_rdy  output  1  one-cycle pulse; a bank just became full.
REQ-016 Port rdy_bank  output  1  index of bank signalled by bank_rdy; held until next pulse.
REQ-017 Port sync_err  output  1  one-cycle pulse on channel-order violation.
REQ-018 Port drop_cnt  output  16  saturating count of samples lost.

Function
REQ-019 Handshake: sample accepted in cycle where s_valid and s_ready both 1.
REQ-020 States SHALL be IDLE, SYNC, FILL, WAIT_BANK.
REQ-021 IDLE: s_ready=0; enable=1 -> SYNC.
REQ-022 SYNC: s_ready=1; samples with s_chan!=0 discarded silently; accepted sample with s_chan==0 written as frame 0 channel 0 -> FILL.
REQ-023 FILL: s_ready=1; expected channel increments mod NUM_CH, frame increments at channel wrap.
REQ-024 FILL: accepted sample with s_chan!=expected channel -> not written, sync_err pulse next cycle, write pointer reset to current bank base, -> SYNC.
REQ-025 Address SHALL be {bank, frame, chan}: bank*256 + frame*NUM_CH + chan, 9 bits.
REQ-026 Write latency: sample accepted in cycle N -> mem_we=1 with mem_addr/mem_din valid in cycle N+1 only; mem_we=0 otherwise.
REQ-027 Last word of bank (frame FRAMES_PER_BANK-1, chan NUM_CH-1) accepted in cycle N -> bank_full[b] set, bank_rdy=1, rdy_bank=b, in cycle N+2.
REQ-028 After bank full: if other bank not full -> continue FILL in other bank at its base; else -> WAIT_BANK.
REQ-029 WAIT_BANK: s_ready=0; each cycle with s_valid=1 increments drop_cnt; on release of target bank -> SYNC for that bank.
REQ-030 bank_release[b] clears bank_full[b] next edge; release of non-full bank ignored.
REQ-031 Release of target bank in same cycle the last word of the other bank is accepted -> no WAIT_BANK entry, FILL continues, zero drops.
REQ-032 Bank switch SHALL introduce no lost cycle: s_ready stays 1 across the switch when target bank free.
REQ-033 drop_cnt saturates at 16'hFFFF; cleared only by reset.
REQ-034 enable=0 in any state -> IDLE next edge; partial bank discarded, pointer reset to current bank base; bank_full and drop_cnt retained; a write already issued (REQ-026) completes.

Reset
REQ-035 rst_n=0 asynchronously forces: state IDLE, current bank 0, pointers 0, s_ready=0, mem_we=0, mem_addr=0, mem_din=0, bank_full=2'b00, bank_rdy=0, rdy_bank=0, sync_err=0, drop_cnt=0.
REQ-036 Reset deassertion mid-stream SHALL resume only via IDLE->SYNC; no write before a channel-0 sample.

Verification
REQ-037 enable=1, 256 in-order samples chan 0..63 x4, data=i -> mem_addr 0..255, mem_din=i, bank_full=01, bank_rdy pulse with rdy_bank=0 two cycles after last accept.
REQ-038 Stream starting at chan 5 -> no mem_we until chan 0; first write mem_addr=0.
REQ-039 Continuous 512 samples, no release -> both banks full, next 10 valid cycles -> s_ready=0, drop_cnt=10; bank_release=01 -> next chan-0 sample written at addr 0.
REQ-040 Chan sequence 0,1,2,4 -> sync_err pulse, word for chan 4 not written, next chan-0 sample written at bank base.
REQ-041 Last word of bank 1 accepted with bank_release=01 same cycle -> writes continue at addr 0, drop_cnt unchanged.
REQ-042 rst_n pulsed low mid-FILL -> all outputs at REQ-035 values immediately, asynchronous to clk.

Source files
------------

// File: rtl/adcmem_writer.sv
// ADC frame writer: aligns the channel stream on channel 0 and writes samples
// into a ping-pong pair of 256-word banks, flagging each bank when it is full.
module adcmem_writer #(
   parameter int NUM_CH          = 64,
   parameter int FRAMES_PER_BANK = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      s_valid,
   input  logic [15:0]               s_data,
   input  logic [$clog2(NUM_CH)-1:0] s_chan,
   output logic                      s_ready,
   input  logic [1:0]                bank_release,
   output logic [8:0]                mem_addr,
   output logic [15:0]               mem_din,
   output logic                      mem_we,
   output logic [1:0]                bank_full,
   output logic                      bank_rdy,
   output logic                      rdy_bank,
   output logic                      sync_err,
   output logic [15:0]               drop_cnt
);

   localparam int CH_W = $clog2(NUM_CH);
   localparam int FR_W = ($clog2(FRAMES_PER_BANK) < 1) ? 1 : $clog2(FRAMES_PER_BANK);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SYNC      = 2'd1,
      FILL      = 2'd2,
      WAIT_BANK = 2'd3
   } state_t;

   state_t            state_r;
   logic              cur_bank_r;
   logic [FR_W-1:0]   frame_r;
   logic [CH_W-1:0]   chan_r;
   logic              pend_full_r;
   logic              pend_bank_r;

   logic              accept_s;
   logic              chan_ok_s;
   logic              wr_s;
   logic              err_s;
   logic              last_ch_s;
   logic              last_fr_s;
   logic              bank_done_s;
   logic              other_s;
   logic              other_free_s;
   logic [7:0]        off_s;
   logic [8:0]        addr_s;
   logic [1:0]        full_set_s;

   // Accept/write decode for the sample presented this cycle.
   always_comb begin
      accept_s     = s_valid && s_ready && enable;
      last_ch_s    = (chan_r == CH_W'(NUM_CH - 1));
      last_fr_s    = (frame_r == FR_W'(FRAMES_PER_BANK - 1));
      other_s      = ~cur_bank_r;
      off_s        = (8'(frame_r) << CH_W) | 8'(chan_r);
      addr_s       = {cur_bank_r, off_s};
      chan_ok_s    = 1'b0;
      wr_s         = 1'b0;
      err_s        = 1'b0;
      case (state_r)
         SYNC: begin
            chan_ok_s = (s_chan == {CH_W{1'b0}});
            wr_s      = accept_s && chan_ok_s;
         end
         FILL: begin
            chan_ok_s = (s_chan == chan_r);
            wr_s      = accept_s && chan_ok_s;
            err_s     = accept_s && !chan_ok_s;
         end
         default: begin
            chan_ok_s = 1'b0;
         end
      endcase
      bank_done_s  = wr_s && last_ch_s && last_fr_s;
      // A release landing on the same edge frees the other bank in time.
      other_free_s = !bank_full[other_s] || bank_release[other_s];
      if (pend_full_r) begin
         full_set_s = pend_bank_r ? 2'b10 : 2'b01;
      end else begin
         full_set_s = 2'b00;
      end
   end

   // Memory write port, bank status flags and error/drop reporting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we      <= 1'b0;
         mem_addr    <= 9'd0;
         mem_din     <= 16'd0;
         sync_err    <= 1'b0;
         pend_full_r <= 1'b0;
         pend_bank_r <= 1'b0;
         bank_rdy    <= 1'b0;
         rdy_bank    <= 1'b0;
         bank_full   <= 2'b00;
         drop_cnt    <= 16'd0;
      end else begin
         mem_we      <= wr_s;
         if (wr_s) begin
            mem_addr <= addr_s;
            mem_din  <= s_data;
         end
         sync_err    <= err_s;
         pend_full_r <= bank_done_s;
         pend_bank_r <= cur_bank_r;
         bank_rdy    <= pend_full_r;
         if (pend_full_r) begin
            rdy_bank <= pend_bank_r;
         end
         // Setting a bank wins over releasing it: a not-yet-full bank ignores release.
         bank_full   <= full_set_s | (bank_full & ~bank_release);
         if ((state_r == WAIT_BANK) && s_valid && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // Control FSM with write pointer and registered ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         s_ready    <= 1'b0;
         cur_bank_r <= 1'b0;
         frame_r    <= {FR_W{1'b0}};
         chan_r     <= {CH_W{1'b0}};
      end else if (!enable) begin
         state_r    <= IDLE;
         s_ready    <= 1'b0;
         frame_r    <= {FR_W{1'b0}};
         chan_r     <= {CH_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               state_r <= SYNC;
               s_ready <= 1'b1;
               frame_r <= {FR_W{1'b0}};
               chan_r  <= {CH_W{1'b0}};
            end
            SYNC: begin
               if (wr_s) begin
                  state_r <= FILL;
                  chan_r  <= CH_W'(1);
               end
            end
            FILL: begin
               if (err_s) begin
                  state_r <= SYNC;
                  frame_r <= {FR_W{1'b0}};
                  chan_r  <= {CH_W{1'b0}};
               end else if (bank_done_s) begin
                  cur_bank_r <= other_s;
                  frame_r    <= {FR_W{1'b0}};
                  chan_r     <= {CH_W{1'b0}};
                  if (other_free_s) begin
                     state_r <= FILL;
                     s_ready <= 1'b1;
                  end else begin
                     state_r <= WAIT_BANK;
                     s_ready <= 1'b0;
                  end
               end else if (wr_s) begin
                  chan_r <= chan_r + CH_W'(1);
                  if (last_ch_s) begin
                     frame_r <= frame_r + FR_W'(1);
                  end
               end
            end
            WAIT_BANK: begin
               if (bank_release[cur_bank_r] && bank_full[cur_bank_r]) begin
                  state_r <= SYNC;
                  s_ready <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               s_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adcmem_writer.sv
// Directed self-checking bench for adcmem_writer: alignment, bank ping-pong,
// sync errors, drop counting, enable drop and asynchronous reset.
module tb_adcmem_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        s_valid;
   logic [15:0] s_data;
   logic [5:0]  s_chan;
   logic        s_ready;
   logic [1:0]  bank_release;
   logic [8:0]  mem_addr;
   logic [15:0] mem_din;
   logic        mem_we;
   logic [1:0]  bank_full;
   logic        bank_rdy;
   logic        rdy_bank;
   logic        sync_err;
   logic [15:0] drop_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   adcmem_writer #(.NUM_CH(64), .FRAMES_PER_BANK(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid),
      .s_data(s_data), .s_chan(s_chan), .s_ready(s_ready),
      .bank_release(bank_release), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_we(mem_we), .bank_full(bank_full), .bank_rdy(bank_rdy),
      .rdy_bank(rdy_bank), .sync_err(sync_err), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one sample for one edge; expect a write of it at exp_addr or none.
   task automatic push(input int ch, input int dat, input logic exp_we,
                       input int exp_addr, input logic [1:0] rel);
      chk("ready_before_push", 32'(s_ready), 32'd1);
      s_valid      = 1'b1;
      s_chan       = 6'(ch);
      s_data       = 16'(dat);
      bank_release = rel;
      tick();
      s_valid      = 1'b0;
      bank_release = 2'b00;
      if (exp_we) begin
         chk($sformatf("write ch%0d", ch), {6'd0, mem_we, mem_addr, mem_din},
             {6'd0, 1'b1, 9'(exp_addr), 16'(dat)});
      end else begin
         chk($sformatf("no_write ch%0d", ch), 32'(mem_we), 32'd0);
      end
   endtask

   // Write words [first..last] of a bank in channel order; optional release on the last word.
   task automatic fill(input int bank, input int first, input int last,
                       input int base, input logic [1:0] rel_last);
      for (int w = first; w <= last; w++) begin
         push(w % 64, base + w, 1'b1, bank * 256 + w, (w == last) ? rel_last : 2'b00);
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = 16'd0;
      s_chan = 6'd0; bank_release = 2'b00;
      tick(); tick();
      chk("rst s_ready",   32'(s_ready),   32'd0);
      chk("rst mem_we",    32'(mem_we),    32'd0);
      chk("rst mem_addr",  32'(mem_addr),  32'd0);
      chk("rst bank_full", 32'(bank_full), 32'd0);
      chk("rst drop_cnt",  32'(drop_cnt),  32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle s_ready", 32'(s_ready), 32'd0);

      // Stream starting mid-frame is discarded until channel 0, then bank 0 fills.
      enable = 1'b1;
      tick();
      chk("sync s_ready", 32'(s_ready), 32'd1);
      for (int c = 5; c < 64; c++) push(c, 16'hDEAD, 1'b0, 0, 2'b00);
      fill(0, 0, 255, 0, 2'b00);
      chk("full at N+1", 32'(bank_full), 32'd0);
      chk("switch keeps ready", 32'(s_ready), 32'd1);
      tick();
      chk("bank0 full",    32'(bank_full), 32'd1);
      chk("bank_rdy pulse", 32'(bank_rdy), 32'd1);
      chk("rdy_bank 0",    32'(rdy_bank),  32'd0);
      tick();
      chk("bank_rdy one cycle", 32'(bank_rdy), 32'd0);

      // Channel order 0,1,2,4 in bank 1 -> sync error, realign at bank 1 base.
      push(0, 100, 1'b1, 256, 2'b00);
      push(1, 101, 1'b1, 257, 2'b00);
      push(2, 102, 1'b1, 258, 2'b00);
      push(4, 104, 1'b0, 0, 2'b00);
      chk("sync_err pulse", 32'(sync_err), 32'd1);
      tick();
      chk("sync_err clears", 32'(sync_err), 32'd0);
      push(0, 16'h0200, 1'b1, 256, 2'b00);

      // Both banks full -> WAIT_BANK, drop ten samples, release bank 0.
      fill(1, 1, 255, 16'h1000, 2'b00);
      chk("wait s_ready", 32'(s_ready), 32'd0);
      s_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k == 0) begin
            chk("both full",  32'(bank_full), 32'd3);
            chk("rdy bank 1", {30'd0, bank_rdy, rdy_bank}, 32'd3);
         end
      end
      s_valid = 1'b0;
      chk("drop_cnt 10", 32'(drop_cnt), 32'd10);
      chk("no write while waiting", 32'(mem_we), 32'd0);
      bank_release = 2'b01;
      tick();
      bank_release = 2'b00;
      chk("bank0 released", 32'(bank_full), 32'd2);
      push(3, 16'hBEEF, 1'b0, 0, 2'b00);
      push(0, 16'h3000, 1'b1, 0, 2'b00);

      // Release of the target bank on the last word: no wait, no drops.
      fill(0, 1, 255, 16'h3000, 2'b10);
      chk("no wait entry", 32'(s_ready), 32'd1);
      push(0, 16'h4000, 1'b1, 256, 2'b00);
      chk("bank0 full again", 32'(bank_full), 32'd1);
      fill(1, 1, 255, 16'h4000, 2'b01);
      chk("no wait entry b1", 32'(s_ready), 32'd1);
      push(0, 16'h5000, 1'b1, 0, 2'b00);
      chk("drop_cnt unchanged", 32'(drop_cnt), 32'd10);
      chk("bank1 full", {30'd0, bank_full}, 32'd2);

      // Enable drop mid-fill: discard partial bank, keep flags and drop count.
      push(1, 16'h5001, 1'b1, 1, 2'b00);
      enable = 1'b0;
      tick();
      chk("disable s_ready",   32'(s_ready),   32'd0);
      chk("disable bank_full", 32'(bank_full), 32'd2);
      chk("disable drop_cnt",  32'(drop_cnt),  32'd10);
      enable = 1'b1;
      tick();
      push(0, 16'h6000, 1'b1, 0, 2'b00);
      push(1, 16'h6001, 1'b1, 1, 2'b00);

      // Asynchronous reset in the middle of a cycle.
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst s_ready",   32'(s_ready),   32'd0);
      chk("arst mem_bus",   {6'd0, mem_we, mem_addr, mem_din}, 32'd0);
      chk("arst bank_full", 32'(bank_full), 32'd0);
      chk("arst flags",     {29'd0, bank_rdy, rdy_bank, sync_err}, 32'd0);
      chk("arst drop_cnt",  32'(drop_cnt),  32'd0);
      tick();
      rst_n = 1'b1;
      chk("resume via idle", 32'(s_ready), 32'd0);
      tick();
      push(7, 16'h7007, 1'b0, 0, 2'b00);
      push(0, 16'h7000, 1'b1, 0, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
